lsu_div_scoreboard: RTL
=======================

Name: lsu_div_scoreboard

Overview:
- Producer-side hazard tracker that complements the EXE-stage forwarding path.
- Records every in-flight GPR write from long-latency producers (loads, MUL/DIV) at issue and clears it at writeback.
- Stalls ID while a source or destination register is still pending, since no forward exists for such values yet.
- Sits between the ID/EXE issue logic and the WB stage; drives the global ID stall together with the existing hazard logic.

Parameters:
- NREG, 32, number of architectural GPRs; register 0 is hard-wired zero.
- MAX_OUT, 4, maximum simultaneously outstanding long-latency writes.
- CNT_W, 3, width of outstanding counter; must satisfy 2^CNT_W > MAX_OUT.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  5  source register A
- id_rt  in  5  source register B
- id_rs_used  in  1  instruction reads rs
- id_rt_used  in  1  instruction reads rt
- id_dst  in  5  destination register
- id_long_wr  in  1  instruction writes id_dst via a long-latency producer
- id_fire  in  1  instruction leaves ID this cycle (upstream guarantees id_fire implies id_valid and not id_stall)
- wb_valid  in  1  long-latency result is written to the register file this cycle
- wb_dst  in  5  destination of that result
- flush  in  1  exception/ERET flush; all in-flight long-latency ops are killed
- id_stall  out  1  hold ID; combinational
- sb_full  out  1  outstanding count equals MAX_OUT
- sb_busy  out  1  outstanding count nonzero
- sb_err  out  1  sticky: writeback hit a non-pending register, or counter underflow/overflow

Behaviour:
- State:
  - pending[NREG-1:0], one bit per register.
  - cnt[CNT_W-1:0], the outstanding count.
  - err, the sticky error flag.
- Reset (resetn low, asynchronous):
  - pending = 0, cnt = 0, err = 0.
  - Hence id_stall = 0, sb_full = 0, sb_busy = 0, sb_err = 0.
- Bypass visibility: eff_pending[r] = pending[r] & ~(wb_valid & wb_dst == r). A value written back this cycle is visible to ID through the regfile write-through, so it does not stall.
- Hazard terms:
  - raw_a = id_rs_used & id_rs != 0 & eff_pending[id_rs]
  - raw_b = id_rt_used & id_rt != 0 & eff_pending[id_rt]
  - waw = id_long_wr & id_dst != 0 & eff_pending[id_dst]
  - cap = id_long_wr & id_dst != 0 & (cnt == MAX_OUT) & ~(wb_valid & pending[wb_dst])
- Stall: id_stall = id_valid & ~flush & (raw_a | raw_b | waw | cap).
- Set: set = id_fire & id_long_wr & id_dst != 0 & ~flush. On set, pending[id_dst] becomes 1 on the next edge.
- Clear: clr = wb_valid & pending[wb_dst] & ~flush. On clr, pending[wb_dst] becomes 0.
- Set and clear of the same register in the same cycle: set wins, pending stays 1.
- Counter: cnt_next = cnt + set - clr, computed in CNT_W+1 bits.
  - Underflow or a value above MAX_OUT sets err and saturates cnt within 0..MAX_OUT.
- Error cases:
  - wb_valid with pending[wb_dst] = 0 and no flush sets err; state is otherwise unchanged.
  - wb_dst = 0 is always ignored and never sets err.
- Flush (synchronous, highest priority):
  - Next edge: pending = 0, cnt = 0.
  - The same-cycle set and clear are suppressed.
  - err is not cleared by flush; only reset clears it.
- Latency:
  - A set becomes visible to id_stall one cycle after id_fire.
  - A clear is visible in the same cycle through the bypass.
- Outputs:
  - sb_full = (cnt == MAX_OUT), registered-state derived.
  - sb_busy = (cnt != 0).
  - sb_err = err.
- Reset mid-operation: everything returns to the reset values immediately. Producers must also be reset, so no stale writeback follows.

Decomposition:
- The shared CPU package gets:
  - the GPR index typedef (5 bits);
  - the constants NREG_GPR and SB_MAX_OUT;
  - a struct IdHazardReq {rs, rt, rs_used, rt_used, dst, long_wr} so the ID stage passes a single bundle.
- One sub-module, sb_lookup: a purely combinational eff_pending select plus the raw/waw compare. It is instantiated once and reused for rs, rt and dst through three read ports.
- Counter, pending array and error logic stay in the top module.

Test Plan:
- Load-use RAW: issue a load to $5 (id_fire, long_wr=1); next cycle ID reads rs=$5 -> id_stall=1. Hold until wb_valid with wb_dst=5 -> id_stall=0 in that same cycle; one cycle later pending[5]=0 and cnt=0.
- Zero register: a long write to $0, then a read of $0 -> id_stall=0 throughout, cnt stays 0, sb_err=0.
- Capacity: issue 4 long writes to $1..$4 -> sb_full=1; a 5th long write to $6 -> id_stall=1. Present wb_dst=2 in the same cycle -> stall drops, cnt remains 4, pending={1,3,4,6}.
- Same-cycle set and clear: pending[7]=1, wb_dst=7 together with id_fire long write to $7 -> pending[7]=1 afterwards, cnt unchanged, no stall.
- Flush: 3 pending entries; assert flush together with an id_fire long write to $9 -> next cycle pending=0, cnt=0, sb_busy=0, pending[9]=0, id_stall=0 while flush is high.
- Error and reset: wb_valid with wb_dst=12 while not pending -> sb_err=1 and stays 1 across a flush. Assert resetn=0 asynchronously mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/lsu_div_scoreboard_pkg.sv
// Shared types and constants for the long-latency GPR write scoreboard.
package lsu_div_scoreboard_pkg;

    localparam int NREG_GPR   = 32;
    localparam int SB_MAX_OUT = 4;
    localparam int SB_CNT_W   = 3;

    typedef logic [4:0] gpr_idx_t;

    // Everything the ID stage knows about the instruction it is holding,
    // bundled so hazard checks take a single argument.
    typedef struct packed {
        gpr_idx_t rs;
        gpr_idx_t rt;
        logic     rs_used;
        logic     rt_used;
        gpr_idx_t dst;
        logic     long_wr;
    } id_hazard_req_t;

    // Register 0 is hard-wired zero and never takes part in hazards.
    function automatic logic gpr_nz(input gpr_idx_t r);
        return r != '0;
    endfunction

endpackage

// File: rtl/lsu_div_scoreboard_sb_lookup.sv
// Combinational pending lookup with writeback bypass for the rs, rt and dst
// read ports of the ID-stage instruction.
module lsu_div_scoreboard_sb_lookup
    import lsu_div_scoreboard_pkg::*;
#(
    parameter int NREG = NREG_GPR
) (
    input  logic [NREG-1:0] i_pending,
    input  logic            i_wb_valid,
    input  gpr_idx_t        i_wb_dst,
    input  id_hazard_req_t  i_req,
    output logic            o_raw_a,
    output logic            o_raw_b,
    output logic            o_waw
);

    logic [NREG-1:0] w_eff_pending;

    // A register written back this cycle reaches ID through the regfile
    // write-through, so it no longer counts as pending.
    always_comb begin
        w_eff_pending = i_pending;
        if (i_wb_valid) begin
            w_eff_pending[i_wb_dst] = 1'b0;
        end
    end

    assign o_raw_a = i_req.rs_used & gpr_nz(i_req.rs)  & w_eff_pending[i_req.rs];
    assign o_raw_b = i_req.rt_used & gpr_nz(i_req.rt)  & w_eff_pending[i_req.rt];
    assign o_waw   = i_req.long_wr & gpr_nz(i_req.dst) & w_eff_pending[i_req.dst];

endmodule

// File: rtl/lsu_div_scoreboard.sv
// Scoreboard of in-flight long-latency GPR writes (loads, MUL/DIV): marks the
// destination at issue, clears it at writeback and stalls ID on hazards.
module lsu_div_scoreboard
    import lsu_div_scoreboard_pkg::*;
#(
    parameter int NREG    = NREG_GPR,
    parameter int MAX_OUT = SB_MAX_OUT,
    parameter int CNT_W   = SB_CNT_W
) (
    input  logic     clk,
    input  logic     resetn,
    input  logic     id_valid,
    input  gpr_idx_t id_rs,
    input  gpr_idx_t id_rt,
    input  logic     id_rs_used,
    input  logic     id_rt_used,
    input  gpr_idx_t id_dst,
    input  logic     id_long_wr,
    input  logic     id_fire,
    input  logic     wb_valid,
    input  gpr_idx_t wb_dst,
    input  logic     flush,
    output logic     id_stall,
    output logic     sb_full,
    output logic     sb_busy,
    output logic     sb_err
);

    localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_OUT);

    logic [NREG-1:0]  r_pending;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    id_hazard_req_t   w_req;
    logic             w_raw_a;
    logic             w_raw_b;
    logic             w_waw;
    logic             w_cap;
    logic             w_full;
    logic             w_wb_hit;
    logic             w_set;
    logic             w_clr;
    logic             w_wb_err;
    logic             w_underflow;
    logic             w_overflow;
    logic [CNT_W:0]   w_cnt_sum;
    logic [NREG-1:0]  w_pending_nxt;

    // Clamp the widened count back into 0..MAX_OUT.
    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W:0] sum,
                                                 input logic           under);
        if (under) begin
            return '0;
        end
        if (sum > MAX_CNT) begin
            return MAX_CNT[CNT_W-1:0];
        end
        return sum[CNT_W-1:0];
    endfunction

    assign w_req = '{rs: id_rs, rt: id_rt, rs_used: id_rs_used, rt_used: id_rt_used,
                     dst: id_dst, long_wr: id_long_wr};

    lsu_div_scoreboard_sb_lookup #(
        .NREG (NREG)
    ) u_lookup (
        .i_pending  (r_pending),
        .i_wb_valid (wb_valid),
        .i_wb_dst   (wb_dst),
        .i_req      (w_req),
        .o_raw_a    (w_raw_a),
        .o_raw_b    (w_raw_b),
        .o_waw      (w_waw)
    );

    assign w_full   = ({1'b0, r_cnt} == MAX_CNT);
    assign w_wb_hit = wb_valid & r_pending[wb_dst];

    // A slot freed by this cycle's writeback is usable by the issuing op.
    assign w_cap    = id_long_wr & gpr_nz(id_dst) & w_full & ~w_wb_hit;
    assign id_stall = id_valid & ~flush & (w_raw_a | w_raw_b | w_waw | w_cap);

    assign w_set    = id_fire & id_long_wr & gpr_nz(id_dst) & ~flush;
    assign w_clr    = w_wb_hit & ~flush;
    assign w_wb_err = wb_valid & gpr_nz(wb_dst) & ~r_pending[wb_dst] & ~flush;

    assign w_cnt_sum   = {1'b0, r_cnt} + (CNT_W+1)'(w_set) - (CNT_W+1)'(w_clr);
    assign w_underflow = (r_cnt == '0) & w_clr & ~w_set;
    assign w_overflow  = ~w_underflow & (w_cnt_sum > MAX_CNT);

    // Next pending vector; set is applied last so it wins a same-register clear.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_clr) begin
            w_pending_nxt[wb_dst] = 1'b0;
        end
        if (w_set) begin
            w_pending_nxt[id_dst] = 1'b1;
        end
    end

    // Pending array and counter; flush drops every in-flight write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pending <= '0;
            r_cnt     <= '0;
        end else if (flush) begin
            r_pending <= '0;
            r_cnt     <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_cnt     <= sat_cnt(w_cnt_sum, w_underflow);
        end
    end

    // Sticky error flag; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (w_wb_err | w_underflow | w_overflow) begin
            r_err <= 1'b1;
        end
    end

    assign sb_full = w_full;
    assign sb_busy = (r_cnt != '0);
    assign sb_err  = r_err;

endmodule
